scs8hd_a22o_bist: RTL

SCS8HD_A22O_BIST -- requirements
Module: scs8hd_a22o_bist

---
 rtl/scs8hd_bist_pkg.sv | 7 +
 rtl/scs8hd_misr16.sv | 15 +
 rtl/scs8hd_a22o_bist.sv | 82 ++++++++
 3 files changed

// File: rtl/scs8hd_bist_pkg.sv
// scs8hd_bist_pkg: shared states and constants for cell BIST blocks
package scs8hd_bist_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} bist_state_t;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;
  localparam int NUM_VEC = 16;
endpackage

// File: rtl/scs8hd_misr16.sv
// scs8hd_misr16: 16-bit Galois MISR with seed load
module scs8hd_misr16
  import scs8hd_bist_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CLR,
  input  logic        EN,
  input  logic        DIN,
  output logic [15:0] SIG
);
  always_ff @(posedge CLK)
    if (RESET || CLR) SIG <= SEED;
    else if (EN) SIG <= {SIG[14:0], 1'b0} ^ (SIG[15] ? POLY : 16'h0) ^ {15'b0, DIN};
endmodule

// File: rtl/scs8hd_a22o_bist.sv
// scs8hd_a22o_bist: exhaustive 16-vector BIST sweep of an a22o cell
module scs8hd_a22o_bist
  import scs8hd_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        ABORT,
  input  logic        X_IN,
  output logic        A1,
  output logic        A2,
  output logic        B1,
  output logic        B2,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [4:0]  FAIL_CNT,
  output logic [15:0] SIG
);
  bist_state_t state, nxt;
  logic [3:0] vec, nvec, cnt, ncnt, stim;
  logic clr, en, exp_x, din, miss;
  assign exp_x = (vec[3] & vec[2]) | (vec[1] & vec[0]);
  // an unknown X_IN counts as a mismatch and shifts in as 1
  assign din  = (X_IN !== 1'b0);
  assign miss = (X_IN !== exp_x);
  always_comb begin
    nxt  = state;
    nvec = vec;
    ncnt = cnt;
    clr  = 1'b0;
    en   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (START) begin
        nxt  = ST_SETTLE;
        nvec = 4'd0;
        ncnt = 4'd0;
        clr  = 1'b1;
      end
      ST_SETTLE: if (ABORT) nxt = ST_IDLE;
        else if (cnt == 4'(SETTLE_CYC - 1)) nxt = ST_CAPTURE;
        else ncnt = cnt + 4'd1;
      ST_CAPTURE: if (ABORT) nxt = ST_IDLE;
        else begin
          en   = 1'b1;
          nxt  = (vec == 4'(NUM_VEC - 1)) ? ST_DONE : ST_SETTLE;
          nvec = (vec == 4'(NUM_VEC - 1)) ? vec : vec + 4'd1;
          ncnt = 4'd0;
        end
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state    <= ST_IDLE;
      vec      <= 4'd0;
      cnt      <= 4'd0;
      stim     <= 4'd0;
      FAIL_CNT <= 5'd0;
    end else begin
      state <= nxt;
      vec   <= nvec;
      cnt   <= ncnt;
      stim  <= (nxt == ST_SETTLE || nxt == ST_CAPTURE) ? nvec : 4'd0;
      if (clr) FAIL_CNT <= 5'd0;
      else if (en && miss && FAIL_CNT != 5'd16) FAIL_CNT <= FAIL_CNT + 5'd1;
    end
  assign {A1, A2, B1, B2} = stim;
  assign BUSY = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign DONE = (state == ST_DONE);
  assign PASS = DONE && (FAIL_CNT == 5'd0);
  scs8hd_misr16 u_misr (
    .CLK  (CLK),
    .RESET(RESET),
    .CLR  (clr),
    .EN   (en),
    .DIN  (din),
    .SIG  (SIG)
  );
endmodule
